// File: rtl/apb2axi_bridge_if.sv
// Bus bundle for the APB3-to-AXI4 bridge: the APB slave side plus the AXI4 master side.
// The bridge uses the slave modport; the APB master and AXI interconnect use master.
interface apb2axi_bridge_if #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned AXI_ID_WIDTH   = 6,
  parameter int unsigned AXI_USER_WIDTH = 6,
  parameter int unsigned APB_ADDR_WIDTH = 12
) ();
  logic                        psel;
  logic                        penable;
  logic                        pwrite;
  logic [APB_ADDR_WIDTH-1:0]   paddr;
  logic [31:0]                 pwdata;
  logic [31:0]                 prdata;
  logic                        pready;
  logic                        pslverr;

  logic                        aw_valid;
  logic                        aw_ready;
  logic [AXI_ADDR_WIDTH-1:0]   aw_addr;
  logic [AXI_ID_WIDTH-1:0]     aw_id;
  logic [7:0]                  aw_len;
  logic [2:0]                  aw_size;
  logic [1:0]                  aw_burst;
  logic                        aw_lock;
  logic [3:0]                  aw_cache;
  logic [2:0]                  aw_prot;
  logic [3:0]                  aw_region;
  logic [3:0]                  aw_qos;
  logic [AXI_USER_WIDTH-1:0]   aw_user;

  logic                        w_valid;
  logic                        w_ready;
  logic [AXI_DATA_WIDTH-1:0]   w_data;
  logic [AXI_DATA_WIDTH/8-1:0] w_strb;
  logic                        w_last;
  logic [AXI_USER_WIDTH-1:0]   w_user;

  logic                        b_valid;
  logic                        b_ready;
  logic [1:0]                  b_resp;

  logic                        ar_valid;
  logic                        ar_ready;
  logic [AXI_ADDR_WIDTH-1:0]   ar_addr;
  logic [AXI_ID_WIDTH-1:0]     ar_id;
  logic [7:0]                  ar_len;
  logic [2:0]                  ar_size;
  logic [1:0]                  ar_burst;
  logic                        ar_lock;
  logic [3:0]                  ar_cache;
  logic [2:0]                  ar_prot;
  logic [3:0]                  ar_region;
  logic [3:0]                  ar_qos;
  logic [AXI_USER_WIDTH-1:0]   ar_user;

  logic                        r_valid;
  logic                        r_ready;
  logic [AXI_DATA_WIDTH-1:0]   r_data;
  logic [1:0]                  r_resp;
  logic                        r_last;

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr,
    output aw_valid, aw_addr, aw_id, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
    output aw_region, aw_qos, aw_user,
    input  aw_ready,
    output w_valid, w_data, w_strb, w_last, w_user,
    input  w_ready,
    input  b_valid, b_resp,
    output b_ready,
    output ar_valid, ar_addr, ar_id, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
    output ar_region, ar_qos, ar_user,
    input  ar_ready,
    input  r_valid, r_data, r_resp, r_last,
    output r_ready
  );

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr,
    input  aw_valid, aw_addr, aw_id, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
    input  aw_region, aw_qos, aw_user,
    output aw_ready,
    input  w_valid, w_data, w_strb, w_last, w_user,
    output w_ready,
    output b_valid, b_resp,
    input  b_ready,
    input  ar_valid, ar_addr, ar_id, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
    input  ar_region, ar_qos, ar_user,
    output ar_ready,
    output r_valid, r_data, r_resp, r_last,
    input  r_ready
  );
endinterface

// File: rtl/apb2axi_bridge.sv
// APB3 slave to AXI4 master bridge: each APB transfer becomes one single-beat AXI4 burst,
// with exactly one transfer in flight.
module apb2axi_bridge #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned AXI_ID_WIDTH   = 6,
  parameter int unsigned AXI_USER_WIDTH = 6,
  parameter int unsigned APB_ADDR_WIDTH = 12,
  parameter logic [31:0] AXI_BASE_ADDR  = 32'h1A10_0000
) (
  input logic               clk_i,
  input logic               rst_i,
  apb2axi_bridge_if.slave   bus
);

  localparam logic [AXI_ADDR_WIDTH-1:0] BaseAddr = AXI_ADDR_WIDTH'(AXI_BASE_ADDR);

  typedef enum logic [2:0] {StIdle, StWaddr, StWresp, StRaddr, StRdata, StResp} state_e;

  state_e                      state_q;
  logic                        aw_valid_q, w_valid_q, aw_done_q, w_done_q;
  logic                        b_ready_q, ar_valid_q, r_ready_q, pready_q, pslverr_q;
  logic [31:0]                 prdata_q;
  logic [AXI_ADDR_WIDTH-1:0]   addr_q;
  logic [AXI_DATA_WIDTH-1:0]   w_data_q;
  logic [AXI_DATA_WIDTH/8-1:0] w_strb_q;

  logic [AXI_ADDR_WIDTH-1:0]   addr_full;
  logic [AXI_DATA_WIDTH/8-1:0] strb_sel;
  logic [31:0]                 r_lane;
  logic                        aw_hs, w_hs, aw_fin, w_fin;

  assign addr_full = {BaseAddr[AXI_ADDR_WIDTH-1:APB_ADDR_WIDTH], bus.paddr};
  assign aw_hs     = aw_valid_q & bus.aw_ready;
  assign w_hs      = w_valid_q & bus.w_ready;
  assign aw_fin    = aw_done_q | aw_hs;
  assign w_fin     = w_done_q | w_hs;

  // A 64-bit bus carries the 32-bit APB word in the lane picked by address bit 2.
  if (AXI_DATA_WIDTH == 64) begin : g_wide
    assign strb_sel = bus.paddr[2] ? 8'hF0 : 8'h0F;
    assign r_lane   = addr_q[2] ? bus.r_data[63:32] : bus.r_data[31:0];
  end else begin : g_narrow
    assign strb_sel = '1;
    assign r_lane   = bus.r_data[31:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      b_ready_q  <= 1'b0;
      ar_valid_q <= 1'b0;
      r_ready_q  <= 1'b0;
      pready_q   <= 1'b0;
      pslverr_q  <= 1'b0;
      prdata_q   <= '0;
      addr_q     <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.psel && !bus.penable) begin
            addr_q   <= addr_full;
            w_data_q <= {(AXI_DATA_WIDTH/32){bus.pwdata}};
            w_strb_q <= strb_sel;
            if (bus.pwrite) begin
              state_q    <= StWaddr;
              aw_valid_q <= 1'b1;
              w_valid_q  <= 1'b1;
            end else begin
              state_q    <= StRaddr;
              ar_valid_q <= 1'b1;
            end
          end
        end
        StWaddr: begin
          if (aw_hs) aw_valid_q <= 1'b0;
          if (w_hs)  w_valid_q  <= 1'b0;
          if (aw_fin && w_fin) begin
            state_q   <= StWresp;
            b_ready_q <= 1'b1;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
          end else begin
            aw_done_q <= aw_fin;
            w_done_q  <= w_fin;
          end
        end
        StWresp: begin
          if (bus.b_valid) begin
            state_q   <= StResp;
            b_ready_q <= 1'b0;
            pslverr_q <= bus.b_resp[1];
            pready_q  <= 1'b1;
          end
        end
        StRaddr: begin
          if (bus.ar_ready) begin
            state_q    <= StRdata;
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b1;
          end
        end
        StRdata: begin
          if (bus.r_valid) begin
            state_q   <= StResp;
            r_ready_q <= 1'b0;
            prdata_q  <= r_lane;
            pslverr_q <= bus.r_resp[1];
            pready_q  <= 1'b1;
          end
        end
        StResp: begin
          state_q   <= StIdle;
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.prdata    = prdata_q;
  assign bus.pready    = pready_q;
  assign bus.pslverr   = pslverr_q;

  assign bus.aw_valid  = aw_valid_q;
  assign bus.aw_addr   = addr_q;
  assign bus.aw_id     = {AXI_ID_WIDTH{1'b0}};
  assign bus.aw_len    = 8'd0;
  assign bus.aw_size   = 3'd2;
  assign bus.aw_burst  = 2'b01;
  assign bus.aw_lock   = 1'b0;
  assign bus.aw_cache  = 4'b0000;
  assign bus.aw_prot   = 3'b000;
  assign bus.aw_region = 4'b0000;
  assign bus.aw_qos    = 4'b0000;
  assign bus.aw_user   = {AXI_USER_WIDTH{1'b0}};

  assign bus.w_valid   = w_valid_q;
  assign bus.w_data    = w_data_q;
  assign bus.w_strb    = w_strb_q;
  assign bus.w_last    = 1'b1;
  assign bus.w_user    = {AXI_USER_WIDTH{1'b0}};

  assign bus.b_ready   = b_ready_q;

  assign bus.ar_valid  = ar_valid_q;
  assign bus.ar_addr   = addr_q;
  assign bus.ar_id     = {AXI_ID_WIDTH{1'b0}};
  assign bus.ar_len    = 8'd0;
  assign bus.ar_size   = 3'd2;
  assign bus.ar_burst  = 2'b01;
  assign bus.ar_lock   = 1'b0;
  assign bus.ar_cache  = 4'b0000;
  assign bus.ar_prot   = 3'b000;
  assign bus.ar_region = 4'b0000;
  assign bus.ar_qos    = 4'b0000;
  assign bus.ar_user   = {AXI_USER_WIDTH{1'b0}};

  assign bus.r_ready   = r_ready_q;

  // Every burst is one beat, and only resp[1] distinguishes an error.
  logic unused_bits;
  assign unused_bits = ^{bus.r_last, bus.b_resp[0], bus.r_resp[0]};

endmodule

// File: tb/tb_apb2axi_bridge.sv
// Drives a 32-bit and a 64-bit bridge with identical APB traffic and AXI timing; a scoreboard
// of expected AXI requests and APB responses is checked by an independent monitor.
module tb_apb2axi_bridge;
  localparam logic [31:0] Base = 32'h1A10_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        psel, penable, pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic        aw_ready, w_ready, b_valid, ar_ready, r_valid;
  logic [1:0]  b_resp, r_resp;
  logic [63:0] r_data64;

  apb2axi_bridge_if #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .AXI_ID_WIDTH(6),
                      .AXI_USER_WIDTH(6), .APB_ADDR_WIDTH(12)) if32 ();
  apb2axi_bridge_if #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(6),
                      .AXI_USER_WIDTH(6), .APB_ADDR_WIDTH(12)) if64 ();

  apb2axi_bridge #(.AXI_DATA_WIDTH(32)) dut32 (.clk_i(clk), .rst_i(rst), .bus(if32));
  apb2axi_bridge #(.AXI_DATA_WIDTH(64)) dut64 (.clk_i(clk), .rst_i(rst), .bus(if64));

  assign if32.psel = psel;      assign if64.psel = psel;
  assign if32.penable = penable; assign if64.penable = penable;
  assign if32.pwrite = pwrite;  assign if64.pwrite = pwrite;
  assign if32.paddr = paddr;    assign if64.paddr = paddr;
  assign if32.pwdata = pwdata;  assign if64.pwdata = pwdata;
  assign if32.aw_ready = aw_ready; assign if64.aw_ready = aw_ready;
  assign if32.w_ready = w_ready;   assign if64.w_ready = w_ready;
  assign if32.b_valid = b_valid;   assign if64.b_valid = b_valid;
  assign if32.b_resp = b_resp;     assign if64.b_resp = b_resp;
  assign if32.ar_ready = ar_ready; assign if64.ar_ready = ar_ready;
  assign if32.r_valid = r_valid;   assign if64.r_valid = r_valid;
  assign if32.r_resp = r_resp;     assign if64.r_resp = r_resp;
  assign if32.r_data = r_data64[31:0];
  assign if64.r_data = r_data64;
  assign if32.r_last = 1'b1;       assign if64.r_last = 1'b1;

  int tests = 0;
  int fails = 0;

  // Per-transfer responder behaviour: ready/valid delays and response contents.
  int          cur_daw, cur_dw, cur_db, cur_dar, cur_dr;
  logic [1:0]  cur_resp;
  logic [63:0] cur_rdata;

  logic [31:0] aw_q   [2][$];
  logic [71:0] w_q    [2][$];
  logic [31:0] ar_q   [2][$];
  logic [32:0] resp_q [2][$];
  logic [31:0] last_prdata [2];
  logic        prev_pready [2];

  logic        mon_aw_hs [2], mon_w_hs [2], mon_ar_hs [2], mon_pready [2], mon_pslverr [2];
  logic [31:0] mon_aw_addr [2], mon_ar_addr [2], mon_prdata [2];
  logic [71:0] mon_w [2];

  assign mon_aw_hs[0]   = if32.aw_valid & if32.aw_ready;
  assign mon_aw_hs[1]   = if64.aw_valid & if64.aw_ready;
  assign mon_w_hs[0]    = if32.w_valid & if32.w_ready;
  assign mon_w_hs[1]    = if64.w_valid & if64.w_ready;
  assign mon_ar_hs[0]   = if32.ar_valid & if32.ar_ready;
  assign mon_ar_hs[1]   = if64.ar_valid & if64.ar_ready;
  assign mon_aw_addr[0] = if32.aw_addr;
  assign mon_aw_addr[1] = if64.aw_addr;
  assign mon_ar_addr[0] = if32.ar_addr;
  assign mon_ar_addr[1] = if64.ar_addr;
  assign mon_w[0]       = {32'h0, if32.w_data, 4'h0, if32.w_strb};
  assign mon_w[1]       = {if64.w_data, if64.w_strb};
  assign mon_pready[0]  = if32.pready;
  assign mon_pready[1]  = if64.pready;
  assign mon_pslverr[0] = if32.pslverr;
  assign mon_pslverr[1] = if64.pslverr;
  assign mon_prdata[0]  = if32.prdata;
  assign mon_prdata[1]  = if64.prdata;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input int d);
    tests++;
    fails++;
    $display("FAIL %s: handshake on dut%0d with nothing expected", name, d);
  endtask

  function automatic logic [31:0] exp_addr(input logic [11:0] a);
    return (Base & 32'hFFFF_F000) | {20'h0, a};
  endfunction

  // AXI slave model: each ready/valid rises once its request has waited the chosen delay.
  initial begin
    int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
    aw_ready = 0; w_ready = 0; b_valid = 0; ar_ready = 0; r_valid = 0;
    b_resp = 0; r_resp = 0; r_data64 = 0;
    forever begin
      @(negedge clk);
      aw_ready = if32.aw_valid && (aw_cnt >= cur_daw);
      aw_cnt   = if32.aw_valid ? aw_cnt + 1 : 0;
      w_ready  = if32.w_valid && (w_cnt >= cur_dw);
      w_cnt    = if32.w_valid ? w_cnt + 1 : 0;
      ar_ready = if32.ar_valid && (ar_cnt >= cur_dar);
      ar_cnt   = if32.ar_valid ? ar_cnt + 1 : 0;
      b_valid  = if32.b_ready && (b_cnt >= cur_db);
      b_cnt    = if32.b_ready ? b_cnt + 1 : 0;
      b_resp   = b_valid ? cur_resp : 2'b00;
      r_valid  = if32.r_ready && (r_cnt >= cur_dr);
      r_cnt    = if32.r_ready ? r_cnt + 1 : 0;
      r_resp   = r_valid ? cur_resp : 2'b00;
      r_data64 = r_valid ? cur_rdata : {$urandom, $urandom};
    end
  end

  // Monitor: samples just before each rising edge.
  initial begin
    prev_pready[0] = 0;
    prev_pready[1] = 0;
    forever begin
      @(negedge clk);
      #4;
      if (rst) begin
        prev_pready[0] = 0;
        prev_pready[1] = 0;
      end else begin
        for (int d = 0; d < 2; d++) begin
          if (mon_aw_hs[d]) begin
            if (aw_q[d].size() == 0) unexpected("aw", d);
            else check($sformatf("aw_addr dut%0d", d), mon_aw_addr[d], aw_q[d].pop_front());
          end
          if (mon_w_hs[d]) begin
            if (w_q[d].size() == 0) unexpected("w", d);
            else check($sformatf("w_data_strb dut%0d", d), mon_w[d], w_q[d].pop_front());
          end
          if (mon_ar_hs[d]) begin
            if (ar_q[d].size() == 0) unexpected("ar", d);
            else check($sformatf("ar_addr dut%0d", d), mon_ar_addr[d], ar_q[d].pop_front());
          end
          if (prev_pready[d]) begin
            check($sformatf("pready_one_cycle dut%0d", d), mon_pready[d], 1'b0);
            check($sformatf("pslverr_after_resp dut%0d", d), mon_pslverr[d], 1'b0);
          end
          if (mon_pready[d]) begin
            if (resp_q[d].size() == 0) unexpected("pready", d);
            else check($sformatf("prdata_pslverr dut%0d", d), {mon_prdata[d], mon_pslverr[d]},
                       resp_q[d].pop_front());
          end
          prev_pready[d] = mon_pready[d];
        end
      end
    end
  end

  task automatic push_expect(input logic wr, input logic [11:0] a, input logic [31:0] wd);
    if (wr) begin
      aw_q[0].push_back(exp_addr(a));
      aw_q[1].push_back(exp_addr(a));
      w_q[0].push_back({32'h0, wd, 8'h0F});
      w_q[1].push_back({wd, wd, (a[2] ? 8'hF0 : 8'h0F)});
    end else begin
      ar_q[0].push_back(exp_addr(a));
      ar_q[1].push_back(exp_addr(a));
      last_prdata[0] = cur_rdata[31:0];
      last_prdata[1] = a[2] ? cur_rdata[63:32] : cur_rdata[31:0];
    end
    resp_q[0].push_back({last_prdata[0], cur_resp[1]});
    resp_q[1].push_back({last_prdata[1], cur_resp[1]});
  endtask

  // One APB transfer; returns in the cycle pready is seen, so a following call is back-to-back.
  task automatic apb_xfer(input logic wr, input logic [11:0] a, input logic [31:0] wd,
                          input string tag);
    int exp_lat, lat;
    logic got;
    exp_lat = wr ? 3 + ((cur_daw > cur_dw) ? cur_daw : cur_dw) + cur_db : 3 + cur_dar + cur_dr;
    push_expect(wr, a, wd);
    @(negedge clk);
    psel = 1; penable = 0; pwrite = wr; paddr = a; pwdata = wd;
    lat = 0;
    got = 0;
    while (!got && lat < 64) begin
      @(negedge clk);
      lat++;
      penable = 1;
      if (if32.pready) got = 1;
    end
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL %s timeout: no pready after %0d cycles, required %0d", tag, lat, exp_lat);
    end else begin
      check({tag, " latency"}, 72'(lat), 72'(exp_lat));
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      psel = 0;
      penable = 0;
    end
  endtask

  task automatic set_timing(input int daw, input int dw, input int db, input int dar,
                            input int dr);
    cur_daw = daw; cur_dw = dw; cur_db = db; cur_dar = dar; cur_dr = dr;
  endtask

  initial begin
    int n;
    logic got;
    psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0;
    set_timing(0, 0, 0, 0, 0);
    cur_resp = 2'b00;
    cur_rdata = 64'h0;
    last_prdata[0] = 0;
    last_prdata[1] = 0;
    rst = 1;
    repeat (3) @(negedge clk);
    check("reset aw_valid", {if32.aw_valid, if64.aw_valid}, 2'b00);
    check("reset w_valid", {if32.w_valid, if64.w_valid}, 2'b00);
    check("reset ar_valid", {if32.ar_valid, if64.ar_valid}, 2'b00);
    check("reset b_r_ready", {if32.b_ready, if64.b_ready, if32.r_ready, if64.r_ready}, 4'h0);
    check("reset pready_pslverr", {if32.pready, if64.pready, if32.pslverr, if64.pslverr}, 4'h0);
    check("reset prdata", {if32.prdata, if64.prdata}, 64'h0);
    check("reset w_strb", {if32.w_strb, if64.w_strb}, 12'h0);
    check("const size_burst_len", {if32.aw_size, if64.ar_size, if32.ar_burst, if64.aw_len},
          {3'd2, 3'd2, 2'b01, 8'd0});
    check("const last_cache_id", {if32.w_last, if64.w_last, if32.aw_cache, if64.ar_id},
          {1'b1, 1'b1, 4'h0, 6'h0});
    rst = 0;
    idle(2);

    // Basic write, all ready.
    apb_xfer(1'b1, 12'h010, 32'hDEADBEEF, "write_basic");
    idle(2);
    // AW ready held off while W completes immediately.
    set_timing(3, 0, 0, 0, 0);
    apb_xfer(1'b1, 12'h020, 32'h0BAD_F00D, "write_aw_delayed");
    idle(2);
    // Read with SLVERR; 64-bit lane picked by addr[2].
    set_timing(0, 0, 0, 0, 0);
    cur_resp = 2'b10;
    cur_rdata = 64'hCAFE_F00D_1234_5678;
    apb_xfer(1'b0, 12'h024, 32'h0, "read_slverr");
    idle(2);
    cur_resp = 2'b00;
    apb_xfer(1'b1, 12'h004, 32'hA5A5_0001, "write_upper_lane");
    idle(1);
    cur_rdata = 64'h8765_4321_0F0F_0F0F;
    apb_xfer(1'b0, 12'h004, 32'h0, "read_upper_lane");
    idle(1);
    cur_resp = 2'b11;
    set_timing(1, 2, 1, 0, 0);
    apb_xfer(1'b1, 12'h008, 32'h1357_9BDF, "write_decerr");
    idle(1);
    // Back-to-back write then read with no idle cycle between.
    cur_resp = 2'b00;
    set_timing(0, 0, 0, 0, 0);
    cur_rdata = 64'h1111_2222_3333_4444;
    apb_xfer(1'b1, 12'h100, 32'h0102_0304, "b2b_write");
    apb_xfer(1'b0, 12'h0F0, 32'h0, "b2b_read");
    idle(2);

    // Reset while waiting for the write response.
    set_timing(0, 0, 6, 0, 0);
    aw_q[0].push_back(exp_addr(12'h040));
    aw_q[1].push_back(exp_addr(12'h040));
    w_q[0].push_back({32'h0, 32'h7777_8888, 8'h0F});
    w_q[1].push_back({32'h7777_8888, 32'h7777_8888, 8'h0F});
    @(negedge clk);
    psel = 1; penable = 0; pwrite = 1; paddr = 12'h040; pwdata = 32'h7777_8888;
    got = 0;
    n = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      penable = 1;
      if (if32.b_ready) got = 1;
    end
    check("reached_wresp", got, 1'b1);
    rst = 1;
    psel = 0;
    penable = 0;
    @(negedge clk);
    rst = 0;
    check("rst_mid b_ready", {if32.b_ready, if64.b_ready}, 2'b00);
    check("rst_mid valids", {if32.aw_valid, if32.w_valid, if64.aw_valid, if64.w_valid}, 4'h0);
    check("rst_mid pready_prdata", {if32.pready, if64.pready, if32.prdata}, 34'h0);
    resp_q[0].delete();
    resp_q[1].delete();
    last_prdata[0] = 0;
    last_prdata[1] = 0;
    set_timing(0, 0, 0, 0, 0);
    cur_rdata = 64'h9999_AAAA_BBBB_CCCC;
    apb_xfer(1'b0, 12'h03C, 32'h0, "after_reset_read");
    idle(1);

    // Random traffic.
    for (int i = 0; i < 40; i++) begin
      logic        wr;
      logic [11:0] a;
      logic [31:0] wd;
      wr = 1'($urandom_range(0, 1));
      a = 12'($urandom);
      wd = $urandom;
      set_timing(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)));
      cur_resp = 2'($urandom);
      cur_rdata = {$urandom, $urandom};
      apb_xfer(wr, a, wd, $sformatf("rand%0d", i));
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
    end
    idle(4);

    for (int d = 0; d < 2; d++) begin
      check($sformatf("aw_q empty dut%0d", d), 72'(aw_q[d].size()), 72'd0);
      check($sformatf("w_q empty dut%0d", d), 72'(w_q[d].size()), 72'd0);
      check($sformatf("ar_q empty dut%0d", d), 72'(ar_q[d].size()), 72'd0);
      check($sformatf("resp_q empty dut%0d", d), 72'(resp_q[d].size()), 72'd0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", fails);
    $fatal(1, "watchdog");
  end

endmodule
